// File: rtl/dma_rd_streamer.sv
// DMA read-side AR streamer: splits one descriptor into AXI INCR bursts that never
// cross a 4 KB page, with a cap on bursts still waiting for RLAST.
module dma_rd_streamer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BEATS  = 16,
    parameter int MAX_OUTSTD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] num_bytes_i,
    input  logic              abort_i,
    output logic              rd_done_o,
    output logic              pend_txn_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [ADDR_W-1:0] ar_addr_o,
    output logic [7:0]        ar_len_o,
    output logic [2:0]        ar_size_o,
    output logic [1:0]        ar_burst_o,
    input  logic              r_fire_i,
    input  logic              r_last_i
);
    localparam int BPB = DATA_W / 8;
    localparam int LG  = $clog2(BPB);
    localparam int CW  = $clog2(MAX_OUTSTD + 1);

    typedef enum logic [2:0] {IDLE, CALC, REQ, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] beats_left;
    logic [8:0]        burst;
    logic [7:0]        len_q;
    logic [CW-1:0]     outstd;
    logic              ar_valid_q;
    logic              rd_done_q;

    logic              ar_fire;
    logic              rl_dec;
    logic [ADDR_W:0]   bytes_rnd;
    logic [ADDR_W-1:0] beats_init;
    logic [ADDR_W-1:0] addr_aligned;
    logic [12:0]       room_bytes;
    logic [12:0]       room_beats;
    logic [8:0]        burst_calc;

    assign ar_fire = ar_valid_q & ar_ready_i;
    // An RLAST with nothing outstanding is stray and must not wrap the counter.
    assign rl_dec  = r_fire_i & r_last_i & (outstd != '0);

    assign bytes_rnd    = {1'b0, num_bytes_i} + (ADDR_W+1)'(BPB - 1);
    assign beats_init   = ADDR_W'(bytes_rnd >> LG);
    assign addr_aligned = src_addr_i & ~ADDR_W'(BPB - 1);
    assign room_bytes   = 13'h1000 - {1'b0, addr[11:0]};
    assign room_beats   = room_bytes >> LG;

    always_comb begin
        burst_calc = 9'(MAX_BEATS);
        if (beats_left < ADDR_W'(MAX_BEATS))
            burst_calc = 9'(beats_left);
        if ({4'b0, burst_calc} > room_beats)
            burst_calc = 9'(room_beats);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            beats_left <= '0;
            burst      <= '0;
            len_q      <= '0;
            outstd     <= '0;
            ar_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
        end else if (abort_i) begin
            state      <= IDLE;
            outstd     <= '0;
            ar_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            outstd    <= outstd + CW'(ar_fire) - CW'(rl_dec);
            case (state)
                IDLE: if (rd_valid_i) begin
                    addr       <= addr_aligned;
                    beats_left <= beats_init;
                    if (num_bytes_i == '0) begin
                        state     <= DONE;
                        rd_done_q <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    burst <= burst_calc;
                    len_q <= 8'(burst_calc - 9'd1);
                    state <= REQ;
                end
                REQ: begin
                    if (ar_fire) begin
                        ar_valid_q <= 1'b0;
                        addr       <= addr + (ADDR_W'(burst) << LG);
                        beats_left <= beats_left - ADDR_W'(burst);
                        state      <= (beats_left == ADDR_W'(burst)) ? DRAIN : CALC;
                    end else if (!ar_valid_q && outstd < CW'(MAX_OUTSTD)) begin
                        // The counter can only fall while we wait, so the cap still holds on assertion.
                        ar_valid_q <= 1'b1;
                    end
                end
                DRAIN: if (outstd == '0) begin
                    state     <= DONE;
                    rd_done_q <= 1'b1;
                end
                DONE: if (!rd_valid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr;
    assign ar_len_o   = len_q;
    assign ar_size_o  = 3'(LG);
    assign ar_burst_o = 2'b01;
    assign rd_done_o  = rd_done_q;
    assign pend_txn_o = ar_valid_q | (outstd != '0);
endmodule
